// File: rtl/cut_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cut_seq_pkg: shared types and constants for the CUT vector sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cut_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_APPLY  = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Pattern generator taps: fb = cur[0]^cur[2]^cur[3]^cur[5], right shift.
  localparam logic [15:0] LFSR_TAPS  = 16'h002D;
  // Signature taps: fb = s[15]^s[14]^s[12]^s[3], left shift.
  localparam logic [15:0] MISR_TAPS  = 16'hD008;
  localparam logic [15:0] SEED_SUBST = 16'h0001;

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? SEED_SUBST : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cut_seq_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cut_seq_lfsr: 16-bit LFSR with load/step; data_in turns it into MISR |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cut_seq_lfsr #(
  parameter logic [15:0] TAPS       = 16'h002D,
  parameter bit          SHIFT_LEFT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  input  logic [15:0] data_in,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;
  logic [15:0] shifted;
  logic        fb;

  assign fb = ^(value_q & TAPS);

  generate
    if (SHIFT_LEFT) begin : g_shift_left
      assign shifted = {value_q[14:0], fb};
    end else begin : g_shift_right
      assign shifted = {fb, value_q[15:1]};
    end
  endgenerate

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (step) begin
      value_d = shifted ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 16'h0000;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/cut_vector_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cut_vector_sequencer: applies stream/LFSR vectors to a CUT, checks   |
// | responses and compacts them into a MISR signature. Revision: 1.0     |
// +----------------------------------------------------------------------+
module cut_vector_sequencer
  import cut_seq_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [IN_W-1:0]  seed,
  input  logic             vec_valid,
  input  logic [IN_W-1:0]  vec_data,
  input  logic [OUT_W-1:0] vec_golden,
  output logic             vec_ready,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [15:0]      signature
);

  localparam int          SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [IN_W-1:0]  cut_in_q, cut_in_d;
  logic [OUT_W-1:0] golden_q, golden_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [CNT_W-1:0] fei_q, fei_d;

  logic        lfsr_load, lfsr_step, misr_load, misr_step;
  logic [15:0] lfsr_val, seed_eff, misr_in;
  logic        abort_act, last_vec, mismatch;

  assign abort_act = abort && (state_q != S_IDLE);
  assign last_vec  = (idx_q == num_q - CNT_W'(1));
  assign mismatch  = (cut_out != golden_q);
  assign seed_eff  = fix_seed(16'(seed));

  always_comb begin
    misr_in              = '0;
    misr_in[OUT_W-1:0]   = cut_out;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_vectors == '0) ? S_DONE : S_LOAD;
      S_LOAD:   if (mode_q || vec_valid) state_d = S_APPLY;
      S_APPLY:  if (settle_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: state_d = last_vec ? S_DONE : S_LOAD;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_act) state_d = S_IDLE;
  end

  // Moore outputs
  always_comb begin
    vec_ready = (state_q == S_LOAD) && !mode_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  always_comb begin
    mode_d    = mode_q;
    num_d     = num_q;
    cut_in_d  = cut_in_q;
    golden_d  = golden_q;
    settle_d  = settle_q;
    idx_d     = idx_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fei_d     = fei_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    misr_load = 1'b0;
    misr_step = 1'b0;
    if (abort_act) begin
      cut_in_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_d    = mode;
            num_d     = num_vectors;
            idx_d     = '0;
            err_d     = '0;
            fev_d     = 1'b0;
            fei_d     = '0;
            lfsr_load = 1'b1;
            misr_load = 1'b1;
          end
        end
        S_LOAD: begin
          if (mode_q) begin
            cut_in_d  = IN_W'(lfsr_val);
            lfsr_step = 1'b1;
            settle_d  = SETTLE_LD;
          end else if (vec_valid) begin
            cut_in_d  = vec_data;
            golden_d  = vec_golden;
            settle_d  = SETTLE_LD;
          end
        end
        S_APPLY: begin
          if (settle_q != '0) settle_d = settle_q - SW'(1);
        end
        S_SAMPLE: begin
          if (!mode_q && mismatch) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = idx_q;
            end
          end
          misr_step = 1'b1;
          if (!last_vec) idx_d = idx_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      num_q    <= '0;
      cut_in_q <= '0;
      golden_q <= '0;
      settle_q <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      fev_q    <= 1'b0;
      fei_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      num_q    <= num_d;
      cut_in_q <= cut_in_d;
      golden_q <= golden_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fei_q    <= fei_d;
    end
  end

  cut_seq_lfsr #(.TAPS(LFSR_TAPS), .SHIFT_LEFT(1'b0)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (seed_eff),
    .step     (lfsr_step),
    .data_in  (16'h0000),
    .value    (lfsr_val)
  );

  cut_seq_lfsr #(.TAPS(MISR_TAPS), .SHIFT_LEFT(1'b1)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (misr_load),
    .load_val (16'h0000),
    .step     (misr_step),
    .data_in  (misr_in),
    .value    (signature)
  );

  assign cut_in          = cut_in_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule
`default_nettype wire

// File: tb/tb_cut_vector_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cut_vector_sequencer: scoreboard bench with a parity CUT stub     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cut_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_vectors = 16'd0;
  logic [15:0] seed = 16'd0;
  logic        vec_valid = 1'b0;
  logic [15:0] vec_data = 16'd0;
  logic        vec_golden = 1'b0;
  logic        vec_ready;
  logic [15:0] cut_in;
  logic        cut_out;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic        first_err_valid;
  logic [15:0] first_err_idx;
  logic [15:0] signature;

  assign cut_out = ^cut_in;

  always #5 clk = ~clk;

  cut_vector_sequencer #(.IN_W(16), .OUT_W(1), .SETTLE(2), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .mode            (mode),
    .num_vectors     (num_vectors),
    .seed            (seed),
    .vec_valid       (vec_valid),
    .vec_data        (vec_data),
    .vec_golden      (vec_golden),
    .vec_ready       (vec_ready),
    .cut_in          (cut_in),
    .cut_out         (cut_out),
    .busy            (busy),
    .done            (done),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .signature       (signature)
  );

  typedef struct packed {
    logic [15:0] err;
    logic        fev;
    logic [15:0] fei;
    logic [15:0] sig;
  } result_t;

  result_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] vd[0:3];
  logic        vg[0:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] e, input logic fv, input logic [15:0] fi,
                          input logic [15:0] s);
    result_t r;
    r.err = e; r.fev = fv; r.fei = fi; r.sig = s;
    exp_q.push_back(r);
  endtask

  // Monitor: every done pulse pops one expected run result.
  always @(negedge clk) begin
    result_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_err_count", err_count, e.err);
        chk("sb_first_err_valid", first_err_valid, e.fev);
        chk("sb_first_err_idx", first_err_idx, e.fei);
        chk("sb_signature", signature, e.sig);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_vec_ready"}, vec_ready, 0);
    chk({tag, "_cut_in"}, cut_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_err_valid"}, first_err_valid, 0);
    chk({tag, "_first_err_idx"}, first_err_idx, 0);
    chk({tag, "_signature"}, signature, 0);
  endtask

  task automatic do_start(input logic m, input logic [15:0] n, input logic [15:0] s);
    start = 1'b1; mode = m; num_vectors = n; seed = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!vec_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!vec_ready) chk("ready_timeout", vec_ready, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  // Stream feeder; vector 'stall' has valid withheld for 5 LOAD cycles.
  task automatic feed(input int n, input int stall);
    logic [15:0] held;
    for (int i = 0; i < n; i++) begin
      if (i == stall) begin
        vec_valid = 1'b0;
        wait_ready();
        held = cut_in;
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          chk("stall_vec_ready", vec_ready, 1);
          chk("stall_cut_in", cut_in, held);
          if (s == 2) begin
            start = 1'b1; mode = 1'b1; num_vectors = 16'd0; seed = 16'hFFFF;
          end
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      vec_valid = 1'b1; vec_data = vd[i]; vec_golden = vg[i];
      wait_ready();
      @(posedge clk); #1;
    end
    vec_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vd[0] = 16'h0001; vg[0] = 1'b1;
    vd[1] = 16'h0003; vg[1] = 1'b0;
    vd[2] = 16'h0007; vg[2] = 1'b1;
    vd[3] = 16'h0000; vg[3] = 1'b0;

    #12;
    chk_zero("por");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stream run, all goldens correct; cycle-accurate cut_in and done.
    push_exp(16'd0, 1'b0, 16'd0, 16'h0005);
    do_start(1'b0, 16'd3, 16'd0);
    fork
      feed(3, -1);
      begin
        for (int k = 0; k <= 12; k++) begin
          @(negedge clk);
          if (k >= 1) chk("t1_cut_in", cut_in, vd[(k-1)/4]);
          chk("t1_done", done, 32'(k == 12));
        end
      end
    join
    wait_idle();

    // Second golden wrong.
    vg[1] = 1'b1;
    push_exp(16'd1, 1'b1, 16'd1, 16'h0005);
    do_start(1'b0, 16'd3, 16'd0);
    feed(3, -1);
    wait_idle();
    vg[1] = 1'b0;

    // Valid withheld on vector 1, start pulsed while busy.
    push_exp(16'd0, 1'b0, 16'd0, 16'h0005);
    do_start(1'b0, 16'd3, 16'd0);
    feed(3, 1);
    wait_idle();

    // Zero-length run.
    push_exp(16'd0, 1'b0, 16'd0, 16'h0000);
    do_start(1'b0, 16'd0, 16'd0);
    @(negedge clk);
    chk("nv0_done", done, 1);
    chk("nv0_busy", busy, 1);
    @(negedge clk);
    chk("nv0_done_after", done, 0);
    chk("nv0_busy_after", busy, 0);

    // LFSR mode, seed 0xACE1.
    push_exp(16'd0, 1'b0, 16'd0, 16'h0001);
    do_start(1'b1, 16'd2, 16'hACE1);
    @(negedge clk);
    @(negedge clk);
    chk("lfsr_vec0", cut_in, 16'hACE1);
    repeat (4) @(negedge clk);
    chk("lfsr_vec1", cut_in, 16'h5670);
    wait_idle();

    // LFSR mode, zero seed substituted.
    push_exp(16'd0, 1'b0, 16'd0, 16'h0001);
    do_start(1'b1, 16'd1, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("lfsr_seed0_vec0", cut_in, 16'h0001);
    wait_idle();

    // Abort during APPLY of vector 1 (vector 0 mismatches).
    vec_valid = 1'b1; vec_data = 16'h0001; vec_golden = 1'b0;
    do_start(1'b0, 16'd3, 16'd0);
    @(posedge clk); #1;
    vec_data = 16'h0003; vec_golden = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_cut_in", cut_in, 16'h0003);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1; vec_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_cut_in", cut_in, 0);
    chk("abort_done", done, 0);
    chk("abort_err_count", err_count, 1);
    chk("abort_first_err_valid", first_err_valid, 1);
    chk("abort_first_err_idx", first_err_idx, 0);
    chk("abort_signature", signature, 16'h0001);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done, 0);

    // Reset asserted mid-APPLY after a mismatch.
    vec_valid = 1'b1; vec_data = 16'h0007; vec_golden = 1'b0;
    do_start(1'b0, 16'd2, 16'd0);
    @(posedge clk); #1;
    vec_data = 16'h0001; vec_golden = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pre_err_count", err_count, 1);
    chk("rst_pre_busy", busy, 1);
    rst_n = 1'b0; vec_valid = 1'b0;
    #2;
    chk_zero("rst");
    @(posedge clk); @(posedge clk); #1;
    chk_zero("rst_hold");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_busy", busy, 0);

    chk("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
